// File: rtl/bottling_line_ctrl_if.sv
// Signal bundle between the bottling sequencer and the switches, sensors and counters.
interface bottling_line_ctrl_if;
    logic       start_i;
    logic       stop_i;
    logic       bottle_sensor_i;
    logic       level_ok_i;
    logic       cork_low_i;
    logic       cork_empty_i;
    logic       recharge_ack_i;
    logic       motor_on_o;
    logic       valve_open_o;
    logic       cork_act_o;
    logic       bottle_done_o;
    logic       cork_use_o;
    logic       dozen_done_o;
    logic       recharge_req_o;
    logic [2:0] recharges_left_o;
    logic [1:0] alarm_o;
    logic [2:0] state_o;

    modport master (
        output start_i, stop_i, bottle_sensor_i, level_ok_i, cork_low_i, cork_empty_i, recharge_ack_i,
        input  motor_on_o, valve_open_o, cork_act_o, bottle_done_o, cork_use_o, dozen_done_o,
               recharge_req_o, recharges_left_o, alarm_o, state_o
    );

    modport slave (
        input  start_i, stop_i, bottle_sensor_i, level_ok_i, cork_low_i, cork_empty_i, recharge_ack_i,
        output motor_on_o, valve_open_o, cork_act_o, bottle_done_o, cork_use_o, dozen_done_o,
               recharge_req_o, recharges_left_o, alarm_o, state_o
    );
endinterface

// File: rtl/bottling_line_ctrl.sv
// Bottling/corking line sequencer: conveyor, fill valve and cork actuator, counter pulses
// and the cork magazine recharge handshake.
module bottling_line_ctrl #(
    parameter int unsigned FILL_TIMEOUT      = 5_000_000,
    parameter int unsigned CORK_CYCLES       = 250_000,
    parameter int unsigned MAX_RECHARGES     = 7,
    parameter int unsigned BOTTLES_PER_DOZEN = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    bottling_line_ctrl_if.slave bus
);
    localparam int unsigned FILL_W = $clog2(FILL_TIMEOUT + 1);
    localparam int unsigned CORK_W = $clog2(CORK_CYCLES + 1);

    // state     | meaning
    // IDLE/FEED | line stopped / conveyor bringing a bottle in
    // FILL/CORK | valve open / actuator pressing a cork
    // RELEASE   | conveyor moving the bottle out; WAIT_CORK awaits refill; FAULT latched
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FEED      = 3'd1,
        FILL      = 3'd2,
        CORK      = 3'd3,
        RELEASE   = 3'd4,
        WAIT_CORK = 3'd5,
        FAULT     = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        start_sync_q, stop_sync_q, bottle_sync_q;
    logic [1:0]        level_sync_q;
    logic [FILL_W-1:0] fill_cnt_q, fill_cnt_d;
    logic [CORK_W-1:0] cork_cnt_q, cork_cnt_d;
    logic              stop_lat_q, stop_lat_d;
    logic              req_q, req_d;
    logic [2:0]        left_q, left_d;
    logic [3:0]        dozen_q, dozen_d;
    logic [1:0]        alarm_q, alarm_d;
    logic              motor_q, valve_q, cork_act_q;
    logic              bottle_done_q, cork_use_q, dozen_done_q;
    logic              start_rise, stop_rise, bottle_rise, bottle_fall, level_ok;
    logic              ack_evt, bottle_evt;

    // bit 0/1 are the synchronizer flops, bit 2 is the edge-detect history
    assign start_rise  = start_sync_q[1] & ~start_sync_q[2];
    assign stop_rise   = stop_sync_q[1] & ~stop_sync_q[2];
    assign bottle_rise = bottle_sync_q[1] & ~bottle_sync_q[2];
    assign bottle_fall = ~bottle_sync_q[1] & bottle_sync_q[2];
    assign level_ok    = level_sync_q[1];
    assign ack_evt     = req_q & bus.recharge_ack_i;

    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        cork_cnt_d = cork_cnt_q;
        stop_lat_d = stop_lat_q;
        alarm_d    = alarm_q;
        dozen_d    = dozen_q;
        bottle_evt = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_rise && !stop_rise) state_d = FEED;
            end
            FEED: begin
                if (stop_rise) begin
                    state_d = IDLE;
                end else if (bottle_rise) begin
                    state_d    = FILL;
                    fill_cnt_d = FILL_W'(FILL_TIMEOUT - 1);
                end
            end
            FILL: begin
                if (stop_rise) stop_lat_d = 1'b1;
                if (level_ok) begin
                    if (bus.cork_empty_i) begin
                        state_d = WAIT_CORK;
                    end else begin
                        state_d    = CORK;
                        cork_cnt_d = CORK_W'(CORK_CYCLES - 1);
                    end
                end else if (fill_cnt_q == '0) begin
                    state_d = FAULT;
                    alarm_d = 2'd1;
                end else begin
                    fill_cnt_d = fill_cnt_q - FILL_W'(1);
                end
            end
            CORK: begin
                if (stop_rise) stop_lat_d = 1'b1;
                if (cork_cnt_q == '0) state_d = RELEASE;
                else                  cork_cnt_d = cork_cnt_q - CORK_W'(1);
            end
            WAIT_CORK: begin
                if (stop_rise) stop_lat_d = 1'b1;
                if (ack_evt) begin
                    state_d    = CORK;
                    cork_cnt_d = CORK_W'(CORK_CYCLES - 1);
                end else if (left_q == 3'd0) begin
                    state_d = FAULT;
                    alarm_d = 2'd2;
                end
            end
            RELEASE: begin
                if (stop_rise) begin
                    state_d    = IDLE;
                    stop_lat_d = 1'b0;
                end else if (bottle_fall) begin
                    bottle_evt = 1'b1;
                    state_d    = stop_lat_q ? IDLE : FEED;
                    stop_lat_d = 1'b0;
                    dozen_d    = (dozen_q == 4'(BOTTLES_PER_DOZEN - 1)) ? 4'd0 : dozen_q + 4'd1;
                end
            end
            FAULT:   state_d = FAULT;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_d  = req_q;
        left_d = left_q;
        if (ack_evt) begin
            req_d  = 1'b0;
            left_d = left_q - 3'd1;
        end else if (!req_q && !bus.recharge_ack_i && state_q != FAULT && left_q != 3'd0 &&
                     (bus.cork_low_i || state_q == WAIT_CORK)) begin
            req_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            start_sync_q  <= '0;
            stop_sync_q   <= '0;
            bottle_sync_q <= '0;
            level_sync_q  <= '0;
            fill_cnt_q    <= '0;
            cork_cnt_q    <= '0;
            stop_lat_q    <= 1'b0;
            req_q         <= 1'b0;
            left_q        <= 3'(MAX_RECHARGES);
            dozen_q       <= '0;
            alarm_q       <= '0;
            motor_q       <= 1'b0;
            valve_q       <= 1'b0;
            cork_act_q    <= 1'b0;
            bottle_done_q <= 1'b0;
            cork_use_q    <= 1'b0;
            dozen_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            start_sync_q  <= {start_sync_q[1:0], bus.start_i};
            stop_sync_q   <= {stop_sync_q[1:0], bus.stop_i};
            bottle_sync_q <= {bottle_sync_q[1:0], bus.bottle_sensor_i};
            level_sync_q  <= {level_sync_q[0], bus.level_ok_i};
            fill_cnt_q    <= fill_cnt_d;
            cork_cnt_q    <= cork_cnt_d;
            stop_lat_q    <= stop_lat_d;
            req_q         <= req_d;
            left_q        <= left_d;
            dozen_q       <= dozen_d;
            alarm_q       <= alarm_d;
            // actuators follow the next state so they switch on the same edge as state_q
            motor_q       <= (state_d == FEED) || (state_d == RELEASE);
            valve_q       <= (state_d == FILL);
            cork_act_q    <= (state_d == CORK);
            cork_use_q    <= (state_d == CORK) && (cork_cnt_d == '0);
            bottle_done_q <= bottle_evt;
            dozen_done_q  <= bottle_evt && (dozen_q == 4'(BOTTLES_PER_DOZEN - 1));
        end
    end

    assign bus.motor_on_o       = motor_q;
    assign bus.valve_open_o     = valve_q;
    assign bus.cork_act_o       = cork_act_q;
    assign bus.bottle_done_o    = bottle_done_q;
    assign bus.cork_use_o       = cork_use_q;
    assign bus.dozen_done_o     = dozen_done_q;
    assign bus.recharge_req_o   = req_q;
    assign bus.recharges_left_o = left_q;
    assign bus.alarm_o          = alarm_q;
    assign bus.state_o          = state_q;
endmodule

// File: tb/tb_bottling_line_ctrl.sv
// Randomized bench for bottling_line_ctrl, checked against a bottle/transaction-level model.
module tb_bottling_line_ctrl;
    localparam int FT  = 40;
    localparam int CC  = 6;
    localparam int MR  = 7;
    localparam int BPD = 12;

    localparam logic [2:0] S_IDLE = 3'd0, S_FEED = 3'd1, S_FILL = 3'd2, S_CORK = 3'd3,
                           S_REL = 3'd4, S_WAIT = 3'd5, S_FAULT = 3'd6;

    logic clk = 1'b0;
    logic rst_n;
    bottling_line_ctrl_if bus();

    bottling_line_ctrl #(
        .FILL_TIMEOUT(FT), .CORK_CYCLES(CC), .MAX_RECHARGES(MR), .BOTTLES_PER_DOZEN(BPD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_bottles = 0;
    int n_use = 0, n_done = 0, n_dozen = 0, n_dozen_alone = 0;
    int act_run = 0, use_pos = 0, last_run = 0, last_use_pos = 0;
    int dozen_at[$];
    logic [2:0] state_log[$];
    logic [2:0] last_st = 3'd0;

    // observer: pulse tallies, cork_act run length and state trace, sampled between edges
    always @(posedge clk) begin
        #2;
        if (bus.cork_act_o) begin
            act_run++;
            if (bus.cork_use_o) use_pos = act_run;
        end else if (act_run != 0) begin
            last_run     = act_run;
            last_use_pos = use_pos;
            act_run      = 0;
            use_pos      = 0;
        end
        if (bus.cork_use_o) n_use++;
        if (bus.bottle_done_o) n_done++;
        if (bus.dozen_done_o) begin
            n_dozen++;
            dozen_at.push_back(n_done);
            if (!bus.bottle_done_o) n_dozen_alone++;
        end
        if (bus.state_o != last_st) begin
            state_log.push_back(bus.state_o);
            last_st = bus.state_o;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
        int n = 0;
        while (bus.state_o != s && n < budget) begin
            cyc(1);
            n++;
        end
        check(tag, int'(bus.state_o), int'(s));
    endtask

    task automatic clear_inputs();
        bus.start_i         = 1'b0;
        bus.stop_i          = 1'b0;
        bus.bottle_sensor_i = 1'b0;
        bus.level_ok_i      = 1'b0;
        bus.cork_low_i      = 1'b0;
        bus.cork_empty_i    = 1'b0;
        bus.recharge_ack_i  = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(2);
    endtask

    task automatic pulse_start();
        bus.start_i = 1'b1;
        cyc(4);
        bus.start_i = 1'b0;
        cyc(1);
    endtask

    task automatic run_bottle(input bit do_stop);
        int gap  = int'($urandom_range(0, 5));
        int lvl  = int'($urandom_range(1, 12));
        int hold = int'($urandom_range(0, 6));
        int done0 = n_done;
        int use0  = n_use;
        logic [2:0] exp_seq [4];
        exp_seq = '{S_FILL, S_CORK, S_REL, do_stop ? S_IDLE : S_FEED};
        cyc(gap);
        state_log.delete();
        bus.bottle_sensor_i = 1'b1;
        wait_state("to_fill", S_FILL, 8);
        if (do_stop) begin
            bus.stop_i = 1'b1;
            cyc(2);
            bus.stop_i = 1'b0;
        end
        cyc(lvl);
        bus.level_ok_i = 1'b1;
        wait_state("to_cork", S_CORK, 8);
        wait_state("to_release", S_REL, CC + 4);
        bus.level_ok_i = 1'b0;
        cyc(hold);
        bus.bottle_sensor_i = 1'b0;
        wait_state("after_release", do_stop ? S_IDLE : S_FEED, 8);
        cyc(2);
        n_bottles++;
        check("seq_len", state_log.size(), 4);
        for (int i = 0; i < 4; i++)
            check("seq_state", (i < state_log.size()) ? int'(state_log[i]) : -1, int'(exp_seq[i]));
        check("bottle_done_one", n_done - done0, 1);
        check("cork_use_one", n_use - use0, 1);
        check("cork_act_len", last_run, CC);
        check("cork_use_pos", last_use_pos, CC);
        check("motor_after", int'(bus.motor_on_o), do_stop ? 0 : 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bad;
        int use0;
        int acks;
        int waits;
        clear_inputs();
        rst_n = 1'b0;
        cyc(3);
        check("rst_state", int'(bus.state_o), 0);
        check("rst_outs", int'({bus.motor_on_o, bus.valve_open_o, bus.cork_act_o, bus.bottle_done_o,
                                bus.cork_use_o, bus.dozen_done_o, bus.recharge_req_o}), 0);
        check("rst_left", int'(bus.recharges_left_o), MR);
        check("rst_alarm", int'(bus.alarm_o), 0);
        rst_n = 1'b1;
        cyc(2);

        bus.start_i = 1'b1;
        cyc(2);
        check("start_lat_early", int'(bus.state_o), int'(S_IDLE));
        cyc(1);
        check("start_lat", int'(bus.state_o), int'(S_FEED));
        check("feed_motor", int'(bus.motor_on_o), 1);
        bus.start_i = 1'b0;

        for (int i = 0; i < 2 * BPD; i++) run_bottle(1'b0);
        check("done_total", n_done, n_bottles);
        check("dozen_total", n_dozen, n_bottles / BPD);
        check("dozen_at_1", (dozen_at.size() > 0) ? dozen_at[0] : -1, BPD);
        check("dozen_at_2", (dozen_at.size() > 1) ? dozen_at[1] : -1, 2 * BPD);
        check("dozen_alone", n_dozen_alone, 0);

        // level_ok arriving on the last allowed FILL cycle still corks
        cyc(2);
        bus.bottle_sensor_i = 1'b1;
        wait_state("lw_fill", S_FILL, 8);
        cyc(FT - 3);
        bus.level_ok_i = 1'b1;
        wait_state("level_wins", S_CORK, 6);
        wait_state("lw_release", S_REL, CC + 4);
        bus.level_ok_i = 1'b0;
        bus.bottle_sensor_i = 1'b0;
        wait_state("lw_feed", S_FEED, 8);
        n_bottles++;

        run_bottle(1'b1);

        bus.start_i = 1'b1;
        bus.stop_i  = 1'b1;
        cyc(6);
        check("start_stop_same", int'(bus.state_o), int'(S_IDLE));
        clear_inputs();
        cyc(2);

        pulse_start();
        wait_state("feed_b", S_FEED, 8);
        bus.stop_i = 1'b1;
        wait_state("stop_in_feed", S_IDLE, 8);
        bus.stop_i = 1'b0;
        cyc(2);

        pulse_start();
        wait_state("feed_c", S_FEED, 8);
        bus.stop_i = 1'b1;
        bus.bottle_sensor_i = 1'b1;
        cyc(6);
        check("stop_beats_sensor", int'(bus.state_o), int'(S_IDLE));
        check("stop_no_valve", int'(bus.valve_open_o), 0);
        clear_inputs();
        cyc(3);
        check("done_total_2", n_done, n_bottles);
        check("use_total_2", n_use, n_bottles);
        check("dozen_total_2", n_dozen, n_bottles / BPD);

        do_reset();
        pulse_start();
        wait_state("to_feed_to", S_FEED, 8);
        bus.bottle_sensor_i = 1'b1;
        wait_state("to_fill_to", S_FILL, 8);
        n = 0;
        while (bus.state_o == S_FILL && n < FT + 20) begin
            cyc(1);
            n++;
        end
        check("fill_cycles", n, FT);
        check("timeout_state", int'(bus.state_o), int'(S_FAULT));
        check("timeout_alarm", int'(bus.alarm_o), 1);
        bad = 0;
        repeat (30) begin
            bus.start_i         = 1'($urandom_range(0, 1));
            bus.stop_i          = 1'($urandom_range(0, 1));
            bus.bottle_sensor_i = 1'($urandom_range(0, 1));
            bus.level_ok_i      = 1'($urandom_range(0, 1));
            cyc(1);
            if (bus.motor_on_o || bus.valve_open_o || bus.cork_act_o) bad++;
            if (bus.state_o != S_FAULT) bad++;
        end
        check("fault_quiet", bad, 0);
        check("fault_alarm_held", int'(bus.alarm_o), 1);

        do_reset();
        bus.cork_low_i = 1'b1;
        pulse_start();
        wait_state("rc_feed", S_FEED, 8);
        bus.bottle_sensor_i = 1'b1;
        wait_state("rc_fill", S_FILL, 8);
        bus.level_ok_i = 1'b1;
        wait_state("rc_cork", S_CORK, 8);
        cyc(2);
        check("rc_cork_act", int'(bus.cork_act_o), 1);
        check("rc_req", int'(bus.recharge_req_o), 1);
        use0 = n_use;
        #3 rst_n = 1'b0;
        #1;
        check("rc_state", int'(bus.state_o), 0);
        check("rc_outs", int'({bus.motor_on_o, bus.valve_open_o, bus.cork_act_o, bus.bottle_done_o,
                               bus.cork_use_o, bus.dozen_done_o, bus.recharge_req_o}), 0);
        check("rc_left", int'(bus.recharges_left_o), MR);
        check("rc_alarm", int'(bus.alarm_o), 0);
        clear_inputs();
        cyc(2);
        rst_n = 1'b1;
        cyc(3);
        check("rc_no_cork_use", n_use - use0, 0);

        do_reset();
        bus.cork_low_i = 1'b1;
        acks = 0;
        for (int k = 0; k < MR; k++) begin
            n = 0;
            while (!bus.recharge_req_o && n < 10) begin
                cyc(1);
                n++;
            end
            check("req_rise", int'(bus.recharge_req_o), 1);
            waits = int'($urandom_range(1, 4));
            cyc(waits);
            check("req_held", int'(bus.recharge_req_o), 1);
            bus.recharge_ack_i = 1'b1;
            cyc(1);
            bus.recharge_ack_i = 1'b0;
            acks++;
            check("req_drop", int'(bus.recharge_req_o), 0);
            check("left", int'(bus.recharges_left_o), MR - acks);
        end
        cyc(10);
        check("req_exhausted", int'(bus.recharge_req_o), 0);
        check("left_zero", int'(bus.recharges_left_o), 0);

        bus.cork_empty_i = 1'b1;
        state_log.delete();
        pulse_start();
        wait_state("ce_feed", S_FEED, 8);
        bus.bottle_sensor_i = 1'b1;
        wait_state("ce_fill", S_FILL, 8);
        bus.level_ok_i = 1'b1;
        wait_state("ce_fault", S_FAULT, 12);
        check("ce_alarm", int'(bus.alarm_o), 2);
        n = 0;
        foreach (state_log[i]) if (state_log[i] == S_WAIT) n++;
        check("ce_wait_seen", n, 1);
        check("ce_actuators", int'({bus.motor_on_o, bus.valve_open_o, bus.cork_act_o}), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/bottling_line_ctrl.md
# bottling_line_ctrl

Sequencing controller for the bottling/corking line. It drives the conveyor, the fill valve and the cork actuator, one bottle at a time. It emits one-cycle `bottle_done`, `cork_use` and `dozen_done` pulses to the existing bottle and cork counters, and requests cork magazine recharges over a req/ack handshake. It sits between the operator switches and sensors on one side and the counter/display datapath on the other.

## Interface
- `FILL_TIMEOUT`, default 5_000_000: max cycles with valve open before a fill fault.
- `CORK_CYCLES`, default 250_000: cork actuator pulse length in cycles.
- `MAX_RECHARGES`, default 7: recharges allowed between resets (3-bit counter).
- `BOTTLES_PER_DOZEN`, default 12: bottles per `dozen_done` pulse.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  operator run switch, asynchronous.
- `stop`  in  1  operator stop switch, asynchronous.
- `bottle_sensor`  in  1  high while a bottle is under the station, asynchronous.
- `level_ok`  in  1  fill level reached, asynchronous.
- `cork_low`  in  1  cork stock at minimum (from cork counter).
- `cork_empty`  in  1  cork stock is zero.
- `recharge_ack`  in  1  magazine has been refilled.
- `motor_on`  out  1  conveyor running.
- `valve_open`  out  1  fill valve open.
- `cork_act`  out  1  cork actuator energized.
- `bottle_done`  out  1  one-cycle pulse per finished bottle.
- `cork_use`  out  1  one-cycle pulse per cork consumed.
- `dozen_done`  out  1  one-cycle pulse per completed dozen.
- `recharge_req`  out  1  recharge request.
- `recharges_left`  out  3  remaining recharges.
- `alarm`  out  2  fault code: 0 none, 1 fill timeout, 2 out of corks.
- `state`  out  3  current state encoding, for debug and display.

## Operation
- **Input conditioning.**
  - `start`, `stop`, `bottle_sensor` and `level_ok` each pass through a 2-flop synchronizer.
  - `start` and `stop` are rising-edge detected after synchronization.
- **States.** IDLE=0, FEED=1, FILL=2, CORK=3, RELEASE=4, WAIT_CORK=5, FAULT=6.
- **Transitions.**
  - IDLE: a rising edge on `start` moves to FEED.
  - FEED: `motor_on`=1. A rising edge on `bottle_sensor` moves to FILL.
  - FILL: `valve_open`=1 and a timer runs.
    - `level_ok` moves to CORK.
    - Timer reaching `FILL_TIMEOUT` moves to FAULT with `alarm`=1.
  - CORK entry: if `cork_empty`=1, go to WAIT_CORK. Otherwise `cork_act`=1 for `CORK_CYCLES`. On the last cycle, pulse `cork_use` and go to RELEASE.
  - WAIT_CORK:
    - With `recharges_left`>0, hold there until the magazine refills, then re-enter CORK.
    - With `recharges_left`=0, go to FAULT with `alarm`=2.
  - RELEASE: `motor_on`=1. A falling edge on `bottle_sensor` pulses `bottle_done`, advances the bottle counter and returns to FEED.
  - FAULT: all actuators are off. Only `rst_n` exits FAULT.
- **Stop.**
  - A `stop` edge in FEED or RELEASE returns to IDLE.
  - In FILL or CORK, `stop` is latched. The current bottle completes through RELEASE, then the FSM goes to IDLE instead of FEED.
- **Recharge handshake.**
  - `recharge_req` rises when `cork_low`=1 (or in WAIT_CORK), `recharges_left`>0 and no request is pending.
  - `recharge_req` holds high until `recharge_ack`=1 is sampled.
  - On the ack cycle: drop `recharge_req` and decrement `recharges_left`.
  - A new request needs `recharge_ack`=0 first.
  - Requests are issued in any non-FAULT state, including IDLE.
- **Dozen count.**
  - Internal 4-bit counter, 0..`BOTTLES_PER_DOZEN`-1, advanced by `bottle_done`.
  - On wrap to 0, `dozen_done` pulses in the same cycle as `bottle_done`.

## Timing
- **Reset values.**
  - State IDLE.
  - All actuators 0, all pulses 0, `recharge_req`=0.
  - `recharges_left`=`MAX_RECHARGES`, `alarm`=0, dozen counter 0, timers 0, stop latch 0.
- **Output registration.** All outputs are registered, with actuator outputs decoded from the next state. An actuator changes on the same edge as the state register.
- **Sensor latency.** A sensor edge on a pin reaches the state change on the 3rd rising `clk` edge: 2 sync flops plus 1 edge-detect flop.
- **Cork timing.**
  - `cork_act` is high for exactly `CORK_CYCLES` cycles.
  - `cork_use` coincides with the last high cycle.
- **Fill timer.**
  - Resets on FILL entry.
  - The fault fires when the count equals `FILL_TIMEOUT`-1 with `level_ok` still low.
  - `level_ok` on that same cycle wins: the FSM goes to CORK.
- **Simultaneous events.**
  - `stop` edge together with a `bottle_sensor` rising edge in FEED: `stop` wins, go to IDLE.
  - `start` and `stop` edges together: `stop` wins.
- **Asynchronous reset.** Asserting `rst_n` in any state forces the reset values within the same cycle, without waiting for `clk`, including mid-handshake; `recharge_req` drops.

## Test plan
- **Single bottle.** Reset, `start` edge, `bottle_sensor` 0→1, `level_ok`=1 after 10 cycles, sensor 1→0 → states 1,2,3,4,1. `cork_act` high exactly `CORK_CYCLES`. One `cork_use` pulse and one `bottle_done` pulse.
- **Dozen.** 12 bottles → exactly one `dozen_done` pulse, coinciding with the 12th `bottle_done`. The 24th bottle gives the second pulse.
- **Fill timeout.** `level_ok` held 0 → `alarm`=1 and state 6 after `FILL_TIMEOUT` cycles. Every actuator stays 0 until `rst_n` is asserted.
- **Recharges.** `cork_low`=1 with ack answered 2 cycles after each req, repeated 7 times → `recharges_left` goes 7→0. Then `cork_empty` on CORK entry → `alarm`=2.
- **Stop during fill.** `stop` edge in FILL → the bottle completes with corking and `bottle_done`, then the state is IDLE with `motor_on`=0.
- **Reset in CORK.** `rst_n` asserted mid-`cork_act` with `recharge_req` high → next sample shows all outputs at reset values and no `cork_use` pulse.
